// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR cells with selectable S=R=1 resolution,
// optional rising-edge request decode and a per-channel minimum-dwell lockout.
module sr_latch_bank #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = 0,
   parameter int unsigned EDGE     = 0,
   parameter int unsigned DWELL    = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] S,
   input  logic [CHANNELS-1:0] R,
   input  logic                clear,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] Qn,
   output logic [CHANNELS-1:0] locked,
   output logic [CHANNELS-1:0] changed
);

   typedef enum logic [1:0] {
      RES_RESET  = 2'd0,
      RES_SET    = 2'd1,
      RES_HOLD   = 2'd2,
      RES_TOGGLE = 2'd3
   } resolve_e;

   localparam resolve_e         C_RES   = resolve_e'(2'(MODE));
   localparam logic [CNT_W-1:0] C_DWELL = CNT_W'(DWELL);

   logic [CHANNELS-1:0] r_q;
   logic [CHANNELS-1:0] r_qn;
   logic [CHANNELS-1:0] r_locked;
   logic [CHANNELS-1:0] r_changed;
   logic [CHANNELS-1:0] r_s_d;
   logic [CHANNELS-1:0] r_r_d;
   logic [CNT_W-1:0]    r_cnt [CHANNELS];

   logic [CHANNELS-1:0] w_s_eff;
   logic [CHANNELS-1:0] w_r_eff;
   logic [CHANNELS-1:0] w_next;
   logic [CNT_W-1:0]    w_cnt_next [CHANNELS];

   // Requests seen while locked are dropped outright; r_locked mirrors r_cnt != 0.
   always_comb begin
      w_s_eff = (EDGE != 0) ? (S & ~r_s_d) : S;
      w_r_eff = (EDGE != 0) ? (R & ~r_r_d) : R;
      w_next  = r_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_cnt_next[i] = r_cnt[i];
         if (!r_locked[i]) begin
            unique case ({w_s_eff[i], w_r_eff[i]})
               2'b10: w_next[i] = 1'b1;
               2'b01: w_next[i] = 1'b0;
               2'b11: begin
                  unique case (C_RES)
                     RES_RESET:  w_next[i] = 1'b0;
                     RES_SET:    w_next[i] = 1'b1;
                     RES_HOLD:   w_next[i] = r_q[i];
                     RES_TOGGLE: w_next[i] = ~r_q[i];
                  endcase
               end
               default: w_next[i] = r_q[i];
            endcase
         end
         if (w_next[i] != r_q[i]) begin
            w_cnt_next[i] = C_DWELL;
         end else if (r_cnt[i] != '0) begin
            w_cnt_next[i] = r_cnt[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= '0;
         r_qn      <= '1;
         r_locked  <= '0;
         r_changed <= '0;
         r_s_d     <= '0;
         r_r_d     <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_s_d <= S;
         r_r_d <= R;
         if (clear) begin
            r_q       <= '0;
            r_qn      <= '1;
            r_locked  <= '0;
            r_changed <= r_q;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               r_cnt[i] <= '0;
            end
         end else begin
            r_q       <= w_next;
            r_qn      <= ~w_next;
            r_changed <= w_next ^ r_q;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               r_cnt[i]    <= w_cnt_next[i];
               r_locked[i] <= (w_cnt_next[i] != '0);
            end
         end
      end
   end

   assign Q       = r_q;
   assign Qn      = r_qn;
   assign locked  = r_locked;
   assign changed = r_changed;

endmodule
